// File: rtl/key_schedule_ctrl.sv
// AES-128 key expansion sequencer: one combinational KeyGeneration step per clock,
// ten steps per cipher key, all eleven round keys held for combinational readout.
module key_schedule_ctrl #(
  parameter int unsigned ROUNDS = 10,
  parameter int unsigned KEY_W  = 128
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [KEY_W-1:0] Key_In,
  output logic             Busy,
  output logic             Done,
  output logic             Keys_Valid,
  input  logic [3:0]       Rd_Addr,
  output logic [KEY_W-1:0] Rd_Key
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_EXPAND = 1'b1;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);
  localparam logic [3:0] MAX_ADDR   = 4'(ROUNDS);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // S-box computed as affine(x^254); x^254 is the GF(2^8) inverse and maps 0 to 0.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    logic [7:0] b;
    sq  = x;
    inv = 8'h01;
    for (int unsigned i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    b = inv;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rc);
    case (rc)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_generation(input logic [3:0] round_count,
                                                  input logic [127:0] k);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    t  = t ^ {rcon(round_count), 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  logic [0:0]       state_q, state_d;
  logic [3:0]       round_q, round_d;
  logic [KEY_W-1:0] work_q, work_d;
  logic [KEY_W-1:0] rk_q [0:ROUNDS];
  logic [KEY_W-1:0] rk_d [0:ROUNDS];
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic [KEY_W-1:0] next_key;
  logic [3:0]       wr_idx;

  assign next_key = key_generation(round_q, work_q);
  assign wr_idx   = round_q + 4'd1;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    work_d  = work_q;
    rk_d    = rk_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          rk_d[0] = Key_In;
          work_d  = Key_In;
          round_d = '0;
          valid_d = 1'b0;
          state_d = S_EXPAND;
        end
      end
      default: begin
        rk_d[wr_idx] = next_key;
        work_d       = next_key;
        round_d      = wr_idx;
        if (round_q == LAST_ROUND) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      round_q <= '0;
      work_q  <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int unsigned i = 0; i <= ROUNDS; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      work_q  <= work_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      rk_q    <= rk_d;
    end
  end

  assign Busy       = (state_q == S_EXPAND);
  assign Done       = done_q;
  assign Keys_Valid = valid_q;

  always_comb begin
    Rd_Key = '0;
    if (Rd_Addr <= MAX_ADDR) Rd_Key = rk_q[Rd_Addr];
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl: FIPS-197 vectors, random keys against a word-level
// key expansion model, and the start/reset/done-cycle corner sequences.
module tb_key_schedule_ctrl;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0;
  logic [127:0] Key_In = '0;
  logic [3:0]   Rd_Addr = '0;
  logic         Busy, Done, Keys_Valid;
  logic [127:0] Rd_Key;

  key_schedule_ctrl #(.ROUNDS(10), .KEY_W(128)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Key_In(Key_In),
    .Busy(Busy), .Done(Done), .Keys_Valid(Keys_Valid),
    .Rd_Addr(Rd_Addr), .Rd_Key(Rd_Key)
  );

  always #20 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   sbox_tbl [0:255];
  logic [127:0] model_rk [0:10];

  typedef struct {
    logic [127:0] key;
    logic [127:0] rk1;
    logic [127:0] rk10;
  } vec_t;
  vec_t vecs [0:1];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // S-box from the generator/log walk: p steps through all nonzero elements by *3,
  // q tracks its inverse by /3.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_tbl[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_tbl[0] = 8'h63;
  endtask

  task automatic compute_model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]], sbox_tbl[t[31:24]]}
            ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic sweep(input string tag, input bit expect_zero);
    logic [127:0] exp;
    for (int a = 0; a < 16; a++) begin
      Rd_Addr = 4'(a);
      #1;
      exp = (expect_zero || a > 10) ? 128'h0 : model_rk[a];
      check($sformatf("%s rk[%0d]", tag, a), Rd_Key, exp);
    end
    Rd_Addr = '0;
  endtask

  // Entered one step after the accepting edge; returns cycles until Done is seen.
  task automatic wait_done(input string tag, output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (!Done && lat < 30) begin
      if (Busy) busy_n++;
      @(posedge Clk); #1;
      lat++;
    end
    if (!Done) check({tag, " done timeout"}, 128'(Done), 128'(1));
  endtask

  task automatic start_and_wait(input string tag, input logic [127:0] key,
                                output int lat, output int busy_n);
    @(posedge Clk); #1;
    Start = 1'b1;
    Key_In = key;
    @(posedge Clk); #1;
    Start = 1'b0;
    wait_done(tag, lat, busy_n);
  endtask

  int lat, busy_n, dones, first_done, second_done;
  logic [127:0] k1;

  initial begin
    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{128'h0,
                128'h62636363626363636263636362636363,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    k1 = vecs[0].key;
    build_sbox();

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    check("reset busy", 128'(Busy), 128'(0));
    check("reset done", 128'(Done), 128'(0));
    check("reset valid", 128'(Keys_Valid), 128'(0));
    compute_model('0);
    sweep("reset", 1'b1);
    Reset = 1'b0;

    // Known-answer vectors
    for (int v = 0; v < 2; v++) begin
      start_and_wait($sformatf("vec%0d", v), vecs[v].key, lat, busy_n);
      check($sformatf("vec%0d latency", v), 128'(lat), 128'(10));
      check($sformatf("vec%0d busy cycles", v), 128'(busy_n), 128'(10));
      check($sformatf("vec%0d busy at done", v), 128'(Busy), 128'(0));
      check($sformatf("vec%0d valid", v), 128'(Keys_Valid), 128'(1));
      @(posedge Clk); #1;
      check($sformatf("vec%0d done width", v), 128'(Done), 128'(0));
      Rd_Addr = 4'd0;  #1; check($sformatf("vec%0d rk0", v), Rd_Key, vecs[v].key);
      Rd_Addr = 4'd1;  #1; check($sformatf("vec%0d rk1", v), Rd_Key, vecs[v].rk1);
      Rd_Addr = 4'd10; #1; check($sformatf("vec%0d rk10", v), Rd_Key, vecs[v].rk10);
      compute_model(vecs[v].key);
      sweep($sformatf("vec%0d", v), 1'b0);
    end

    // Random keys against the model
    for (int n = 0; n < 6; n++) begin
      logic [127:0] rk;
      rk = {$urandom, $urandom, $urandom, $urandom};
      start_and_wait($sformatf("rand%0d", n), rk, lat, busy_n);
      check($sformatf("rand%0d latency", n), 128'(lat), 128'(10));
      compute_model(rk);
      sweep($sformatf("rand%0d", n), 1'b0);
    end

    // Start during expansion is ignored
    @(posedge Clk); #1;
    Start = 1'b1; Key_In = k1;
    @(posedge Clk); #1;
    Start = 1'b0;
    dones = 0; first_done = 0;
    for (int c = 1; c <= 25; c++) begin
      if (c == 4) begin Start = 1'b1; Key_In = '0; end
      else Start = 1'b0;
      @(posedge Clk); #1;
      if (Done) begin dones++; if (first_done == 0) first_done = c; end
    end
    Start = 1'b0;
    check("busy-start done count", 128'(dones), 128'(1));
    check("busy-start done cycle", 128'(first_done), 128'(10));
    compute_model(k1);
    sweep("busy-start", 1'b0);

    // Reset mid-expansion
    @(posedge Clk); #1;
    Start = 1'b1; Key_In = k1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    check("midreset busy", 128'(Busy), 128'(0));
    check("midreset done", 128'(Done), 128'(0));
    check("midreset valid", 128'(Keys_Valid), 128'(0));
    sweep("midreset", 1'b1);
    @(posedge Clk); #1;
    Reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge Clk); #1;
      if (Done) dones++;
    end
    check("midreset no done", 128'(dones), 128'(0));
    check("midreset still idle", 128'(Busy), 128'(0));

    // Restart accepted in the Done cycle
    start_and_wait("done-restart first", k1, lat, busy_n);
    Start = 1'b1; Key_In = '0;
    @(posedge Clk); #1;
    Start = 1'b0;
    check("done-restart valid drop", 128'(Keys_Valid), 128'(0));
    check("done-restart busy", 128'(Busy), 128'(1));
    check("done-restart done low", 128'(Done), 128'(0));
    wait_done("done-restart", lat, busy_n);
    check("done-restart latency", 128'(lat), 128'(10));
    compute_model('0);
    sweep("done-restart", 1'b0);

    // Start held high restarts every time the FSM returns to idle
    @(posedge Clk); #1;
    Start = 1'b1; Key_In = k1;
    @(posedge Clk); #1;
    first_done = 0; second_done = 0;
    for (int c = 1; c <= 23; c++) begin
      @(posedge Clk); #1;
      if (Done) begin
        if (first_done == 0) first_done = c;
        else if (second_done == 0) second_done = c;
      end
    end
    Start = 1'b0;
    check("held-start first done", 128'(first_done), 128'(10));
    check("held-start second done", 128'(second_done), 128'(21));
    repeat (12) @(posedge Clk);
    #1;
    compute_model(k1);
    sweep("held-start", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
